// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and flag layout for the sequential ALU.
// Latency: n/a (definitions only). Backpressure: n/a.
// Flag bits exist in every build; they are only populated when ALU_FLAGS_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_MUL = 4'b0011
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;

    // Bit order matches out_flags: ovf in [FLAG_OVF], zero in [FLAG_ZERO].
    typedef struct packed {
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier datapath, one partial product per step.
// Latency: WIDTH steps after load; last flags the step that produces the final product.
// Backpressure: none; the owner only asserts step while it wants the unit to advance.
module alu_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign last     = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked add/sub/mul ALU with a registered 2*WIDTH result; flags enabled by ALU_FLAGS_EN.
// Latency: add/sub/illegal raise out_valid at the accept edge; mul raises it WIDTH edges later.
// Backpressure: result and flags hold while out_ready=0; no new accept until the result drains.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         out_flags
);

    state_e             state;
    logic [2*WIDTH-1:0] a_ext, b_ext, sum, diff;
    logic [2*WIDTH-1:0] single_res, res_nxt, acc_next;
    logic               accept, mul_load, mul_step, mul_last, res_wr;

    assign a_ext    = {{WIDTH{1'b0}}, a};
    assign b_ext    = {{WIDTH{1'b0}}, b};
    assign sum      = a_ext + b_ext;
    assign diff     = a_ext - b_ext;
    assign accept   = in_valid && in_ready;
    assign mul_load = accept && (opcode == OP_MUL);
    assign mul_step = (state == MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mul_load),
        .step     (mul_step),
        .a        (a),
        .b        (b),
        .acc_next (acc_next),
        .last     (mul_last)
    );

    always_comb begin
        single_res = '0;
        case (opcode)
            OP_ADD:  single_res = sum;
            OP_SUB:  single_res = diff;
            default: single_res = '0;
        endcase
    end

    // The result register loads either from a single-cycle op or the final multiply step.
    assign res_wr  = (accept && (opcode != OP_MUL)) || (mul_step && mul_last);
    assign res_nxt = mul_step ? acc_next : single_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            if (res_wr)
                result <= res_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (opcode == OP_MUL) begin
                            state <= MUL;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    flags_t flags_q;
    logic   ovf_nxt;

    always_comb begin
        ovf_nxt = 1'b0;
        if (mul_step) begin
            ovf_nxt = |acc_next[2*WIDTH-1:WIDTH];
        end else begin
            case (opcode)
                OP_ADD:  ovf_nxt = sum[WIDTH];
                OP_SUB:  ovf_nxt = (a < b);
                default: ovf_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (res_wr) begin
            flags_q.ovf  <= ovf_nxt;
            flags_q.zero <= (res_nxt == '0);
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 2'b00;
`endif

endmodule
